demux144_seq: RTL and testbench

Sequencer for the 4-bit-to-16-bit nibble demultiplexer in the symbol datapath. It accepts a stream of 4-bit symbols over a valid/ready handshake and drives the demultiplexer's data and select inputs so that four consecutive nibbles land in the four 16-bit slots, MSB slot first. It captures each demultiplexer slot into a holding register, because unselected demultiplexer outputs are tri-stated. It presents each completed 16-bit word downstream over a second valid/ready handshake, with back-pressure and a flush that pads partial words.

---
 rtl/demux144_seq.sv | 186 ++++++++++++++++++
 tb/tb_demux144_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux144_seq.sv
// demux144_seq
//   Sequencer for the 4-bit-to-16-bit nibble demultiplexer. Incoming nibbles
//   are steered into the demultiplexer (data + select). The selected
//   demultiplexer slot is captured into a holding register, because the
//   unselected demultiplexer outputs are tri-stated. Four nibbles, MSB slot
//   first, form a 16-bit word that is offered downstream. A flush closes a
//   partial word by padding its unfilled slots with pPadNibble.
//
// Ports
//   inClk, inRst  : clock and synchronous active-high reset
//   inNibData     : incoming nibble        inNibValid   : nibble valid
//   outNibReady   : nibble accepted this cycle when inNibValid is high
//   outDemuxData  : demultiplexer data (combinational copy of inNibData)
//   outDemuxSel   : demultiplexer select (registered slot index)
//   inDemuxData   : demultiplexer 16-bit output bus
//   inFlush       : single-cycle request to close a partial word
//   outWord       : assembled word         outWordValid : word valid
//   inWordReady   : downstream accepts outWord
//   outSlot       : nibbles held in the current partial word (0..3)
//   outDbgState   : FSM state (0 = FILL, 1 = FULL)
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both high. A producer holding valid keeps its data stable
// until that edge; ready may depend combinationally on the consumer's
// ready (outNibReady follows inWordReady), never on the producer's valid.

module demux144_seq #(
    parameter logic [3:0] pPadNibble = 4'h0
) (
    input  logic        inClk,
    input  logic        inRst,
    input  logic [3:0]  inNibData,
    input  logic        inNibValid,
    output logic        outNibReady,
    output logic [3:0]  outDemuxData,
    output logic [1:0]  outDemuxSel,
    input  logic [15:0] inDemuxData,
    input  logic        inFlush,
    output logic [15:0] outWord,
    output logic        outWordValid,
    input  logic        inWordReady,
    output logic [1:0]  outSlot,
    output logic        outDbgState
);

    typedef enum logic {
        sFill = 1'b0,
        sFull = 1'b1
    } seqStateT;

    seqStateT    state;
    seqStateT    stateNext;

    logic [1:0]  slot;
    logic [15:0] assy;
    logic [15:0] wordReg;
    logic        flushPend;

    logic        accept;
    logic        flushNow;
    logic        newWordNib;
    logic        newWordFlush;
    logic        newWord;
    logic [3:0]  capNib;
    logic [15:0] assyMerged;
    logic [15:0] wordNext;
    logic [2:0]  fillAfter;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge inClk) begin
        if (inRst) begin
            state <= sFill;
        end else begin
            state <= stateNext;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // A completing word can only occur in FULL when the held word is
    // leaving the same cycle, so FULL->FULL is the back-to-back case.
    // ------------------------------------------------------------------
    always_comb begin
        stateNext = state;
        case (state)
            sFill: if (newWord) stateNext = sFull;
            sFull: if (inWordReady && !newWord) stateNext = sFill;
            default: stateNext = sFill;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        outWordValid = (state == sFull);
        // Word slot is free, or is being emptied on this edge.
        outNibReady  = (state == sFill) || inWordReady;
        outDbgState  = state;
    end

    assign outDemuxData = inNibData;
    assign outDemuxSel  = slot;
    assign outSlot      = slot;
    assign outWord      = wordReg;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign accept = inNibValid && outNibReady;

    // Only the selected demultiplexer slot carries driven data.
    always_comb begin
        capNib = 4'h0;
        case (slot)
            2'd0: capNib = inDemuxData[15:12];
            2'd1: capNib = inDemuxData[11:8];
            2'd2: capNib = inDemuxData[7:4];
            2'd3: capNib = inDemuxData[3:0];
            default: capNib = 4'h0;
        endcase
    end

    always_comb begin
        assyMerged = assy;
        if (accept) begin
            case (slot)
                2'd0: assyMerged[15:12] = capNib;
                2'd1: assyMerged[11:8]  = capNib;
                2'd2: assyMerged[7:4]   = capNib;
                2'd3: assyMerged[3:0]   = capNib;
                default: assyMerged = assy;
            endcase
        end
    end

    // Fill level once this cycle's nibble (if any) is merged: 0..4.
    assign fillAfter = {1'b0, slot} + {2'b00, accept};

    // Slots at or above the fill level take the pad nibble. For a word
    // completed by its fourth nibble fillAfter is 4, so nothing is padded.
    always_comb begin
        wordNext = assyMerged;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) >= fillAfter) begin
                wordNext[4*(3-i) +: 4] = pPadNibble;
            end
        end
    end

    // A flush (new or pending) acts only when the word slot is free this
    // cycle. In FULL the slot index is always 0, so a pending flush only
    // produces a word if a nibble is accepted in the cycle it is applied.
    assign flushNow     = (inFlush || flushPend) && outNibReady;
    assign newWordNib   = accept && (slot == 2'd3);
    assign newWordFlush = flushNow && ((slot != 2'd0) || accept) && !newWordNib;
    assign newWord      = newWordNib || newWordFlush;

    always_ff @(posedge inClk) begin
        if (inRst) begin
            slot      <= 2'd0;
            assy      <= 16'h0000;
            wordReg   <= 16'h0000;
            flushPend <= 1'b0;
        end else begin
            if (accept) begin
                assy <= assyMerged;
                slot <= slot + 2'd1;
            end
            if (newWord) begin
                wordReg <= wordNext;
                slot    <= 2'd0;
            end
            // Hold (and merge) flushes while the word slot is blocked;
            // a pending flush is consumed the first cycle the slot frees.
            if (!outNibReady) begin
                flushPend <= flushPend || inFlush;
            end else begin
                flushPend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_demux144_seq.sv
// Self-checking bench for demux144_seq. A behavioural demultiplexer drives
// random data on unselected slots so only the selected slot is meaningful.
// Inputs change 1 ns after the rising edge; the word monitor samples on
// the falling edge.

module tb_demux144_seq;

    logic        inClk;
    logic        inRst;
    logic [3:0]  inNibData;
    logic        inNibValid;
    logic        outNibReady;
    logic [3:0]  outDemuxData;
    logic [1:0]  outDemuxSel;
    logic [15:0] inDemuxData;
    logic        inFlush;
    logic [15:0] outWord;
    logic        outWordValid;
    logic        inWordReady;
    logic [1:0]  outSlot;
    logic        outDbgState;

    logic [15:0] noise;
    logic [15:0] expQ[$];
    int          nChecks;
    int          nPass;

    demux144_seq #(.pPadNibble(4'h0)) dut (
        .inClk       (inClk),
        .inRst       (inRst),
        .inNibData   (inNibData),
        .inNibValid  (inNibValid),
        .outNibReady (outNibReady),
        .outDemuxData(outDemuxData),
        .outDemuxSel (outDemuxSel),
        .inDemuxData (inDemuxData),
        .inFlush     (inFlush),
        .outWord     (outWord),
        .outWordValid(outWordValid),
        .inWordReady (inWordReady),
        .outSlot     (outSlot),
        .outDbgState (outDbgState)
    );

    // ---------------- clock / reset ----------------
    initial begin
        inClk = 1'b0;
        forever #5 inClk = ~inClk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- demultiplexer model ----------------
    always @(posedge inClk) noise <= 16'($urandom);

    always_comb begin
        inDemuxData = noise;
        case (outDemuxSel)
            2'd0: inDemuxData[15:12] = outDemuxData;
            2'd1: inDemuxData[11:8]  = outDemuxData;
            2'd2: inDemuxData[7:4]   = outDemuxData;
            default: inDemuxData[3:0] = outDemuxData;
        endcase
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge inClk) begin
        if (!inRst && outWordValid && inWordReady) begin
            nChecks++;
            if (expQ.size() == 0) begin
                $display("FAIL word_unexpected: got %h required none", outWord);
            end else begin
                logic [15:0] e;
                e = expQ.pop_front();
                if (outWord !== e) $display("FAIL word_value: got %h required %h", outWord, e);
                else nPass++;
            end
        end
    end

    // ---------------- drivers ----------------
    // Apply inputs for one clock edge and return 1 ns after it.
    task automatic cyc(input logic v, input logic [3:0] d, input logic f, input logic r);
        inNibValid  = v;
        inNibData   = d;
        inFlush     = f;
        inWordReady = r;
        @(posedge inClk);
        #1;
    endtask

    // Send the top n nibbles of w, MSB first, on consecutive cycles.
    task automatic sendNibs(input logic [15:0] w, input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(1'b1, w[4*(3-i) +: 4], 1'b0, r);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        inRst = 1'b1;
        repeat (3) cyc(1'b0, 4'h0, 1'b0, 1'b0);
        nChecks++; if (outWordValid !== 1'b0) $display("FAIL rst_valid: got %b required 0", outWordValid); else nPass++;
        nChecks++; if (outWord !== 16'h0000) $display("FAIL rst_word: got %h required 0000", outWord); else nPass++;
        nChecks++; if (outSlot !== 2'd0) $display("FAIL rst_slot: got %0d required 0", outSlot); else nPass++;
        nChecks++; if (outDemuxSel !== 2'd0) $display("FAIL rst_sel: got %0d required 0", outDemuxSel); else nPass++;
        inRst = 1'b0;
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        nChecks++; if (outNibReady !== 1'b1) $display("FAIL rst_ready: got %b required 1", outNibReady); else nPass++;
    endtask

    task automatic test_basic();
        expQ.push_back(16'h1234);
        for (int i = 0; i < 4; i++) begin
            nChecks++; if (outDemuxSel !== 2'(i)) $display("FAIL basic_sel%0d: got %0d required %0d", i, outDemuxSel, i); else nPass++;
            nChecks++; if (outWordValid !== 1'b0) $display("FAIL basic_early%0d: got %b required 0", i, outWordValid); else nPass++;
            cyc(1'b1, 4'(i + 1), 1'b0, 1'b1);
        end
        nChecks++; if (outWordValid !== 1'b1) $display("FAIL basic_valid: got %b required 1", outWordValid); else nPass++;
        nChecks++; if (outWord !== 16'h1234) $display("FAIL basic_word: got %h required 1234", outWord); else nPass++;
        nChecks++; if (outDemuxSel !== 2'd0) $display("FAIL basic_sel_wrap: got %0d required 0", outDemuxSel); else nPass++;
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        nChecks++; if (outWordValid !== 1'b0) $display("FAIL basic_drain: got %b required 0", outWordValid); else nPass++;
    endtask

    task automatic test_stream();
        logic [31:0] nibs;
        nibs = 32'hABCDEF01;
        expQ.push_back(16'hABCD);
        expQ.push_back(16'hEF01);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, nibs[4*(8-k) +: 4], 1'b0, 1'b1);
            nChecks++;
            if (outWordValid !== ((k == 4) || (k == 8)))
                $display("FAIL stream_valid%0d: got %b required %b", k, outWordValid, (k == 4) || (k == 8));
            else nPass++;
            nChecks++; if (outNibReady !== 1'b1) $display("FAIL stream_ready%0d: got %b required 1", k, outNibReady); else nPass++;
        end
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        expQ.push_back(16'h1234);
        sendNibs(16'h1234, 4, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 4'h5, 1'b0, 1'b0);
            nChecks++; if (outWord !== 16'h1234) $display("FAIL bp_word%0d: got %h required 1234", k, outWord); else nPass++;
            nChecks++; if (outWordValid !== 1'b1) $display("FAIL bp_valid%0d: got %b required 1", k, outWordValid); else nPass++;
            nChecks++; if (outNibReady !== 1'b0) $display("FAIL bp_ready%0d: got %b required 0", k, outNibReady); else nPass++;
            nChecks++; if (outSlot !== 2'd0) $display("FAIL bp_slot%0d: got %0d required 0", k, outSlot); else nPass++;
        end
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        nChecks++; if (outWordValid !== 1'b0) $display("FAIL bp_release: got %b required 0", outWordValid); else nPass++;
    endtask

    task automatic test_flush();
        expQ.push_back(16'h7800);
        sendNibs(16'h7800, 2, 1'b1);
        cyc(1'b0, 4'h0, 1'b1, 1'b1);
        nChecks++; if (outWordValid !== 1'b1) $display("FAIL flush_valid: got %b required 1", outWordValid); else nPass++;
        nChecks++; if (outWord !== 16'h7800) $display("FAIL flush_word: got %h required 7800", outWord); else nPass++;
        nChecks++; if (outSlot !== 2'd0) $display("FAIL flush_slot: got %0d required 0", outSlot); else nPass++;
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        // Flush alone at slot 0 must not produce a word.
        cyc(1'b0, 4'h0, 1'b1, 1'b1);
        nChecks++; if (outWordValid !== 1'b0) $display("FAIL flush_empty: got %b required 0", outWordValid); else nPass++;
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        nChecks++; if (outWordValid !== 1'b0) $display("FAIL flush_empty2: got %b required 0", outWordValid); else nPass++;
    endtask

    task automatic test_flush_merge();
        expQ.push_back(16'h5690);
        sendNibs(16'h5600, 2, 1'b1);
        cyc(1'b1, 4'h9, 1'b1, 1'b1);
        nChecks++; if (outWord !== 16'h5690) $display("FAIL merge_word: got %h required 5690", outWord); else nPass++;
        nChecks++; if (outWordValid !== 1'b1) $display("FAIL merge_valid: got %b required 1", outWordValid); else nPass++;
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        // Flush together with the slot-3 nibble: exactly one word.
        expQ.push_back(16'hABCD);
        sendNibs(16'hABCD, 3, 1'b1);
        cyc(1'b1, 4'hD, 1'b1, 1'b1);
        nChecks++; if (outWord !== 16'hABCD) $display("FAIL merge3_word: got %h required abcd", outWord); else nPass++;
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        nChecks++; if (outWordValid !== 1'b0) $display("FAIL merge3_single: got %b required 0", outWordValid); else nPass++;
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        nChecks++; if (outWordValid !== 1'b0) $display("FAIL merge3_single2: got %b required 0", outWordValid); else nPass++;
    endtask

    task automatic test_back_to_back();
        // Flush held while blocked, applied on release with a nibble in
        // the same cycle: the next word completes back-to-back.
        expQ.push_back(16'h1234);
        expQ.push_back(16'h3000);
        sendNibs(16'h1234, 4, 1'b1);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        nChecks++; if (outWord !== 16'h1234) $display("FAIL b2b_hold: got %h required 1234", outWord); else nPass++;
        cyc(1'b1, 4'h3, 1'b0, 1'b1);
        nChecks++; if (outWordValid !== 1'b1) $display("FAIL b2b_valid: got %b required 1", outWordValid); else nPass++;
        nChecks++; if (outWord !== 16'h3000) $display("FAIL b2b_word: got %h required 3000", outWord); else nPass++;
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        nChecks++; if (outWordValid !== 1'b0) $display("FAIL b2b_drain: got %b required 0", outWordValid); else nPass++;
    endtask

    task automatic test_reset_mid();
        sendNibs(16'h1230, 3, 1'b1);
        inRst = 1'b1;
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        inRst = 1'b0;
        nChecks++; if (outSlot !== 2'd0) $display("FAIL rmid_slot: got %0d required 0", outSlot); else nPass++;
        nChecks++; if (outWord !== 16'h0000) $display("FAIL rmid_word: got %h required 0000", outWord); else nPass++;
        nChecks++; if (outWordValid !== 1'b0) $display("FAIL rmid_valid: got %b required 0", outWordValid); else nPass++;
        // Word completed but held, then discarded by reset.
        sendNibs(16'h4567, 4, 1'b0);
        nChecks++; if (outWordValid !== 1'b1) $display("FAIL rheld_valid: got %b required 1", outWordValid); else nPass++;
        inRst = 1'b1;
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        inRst = 1'b0;
        nChecks++; if (outWordValid !== 1'b0) $display("FAIL rheld_clr: got %b required 0", outWordValid); else nPass++;
        nChecks++; if (outWord !== 16'h0000) $display("FAIL rheld_word: got %h required 0000", outWord); else nPass++;
        expQ.push_back(16'h9ABC);
        sendNibs(16'h9ABC, 4, 1'b1);
        nChecks++; if (outWord !== 16'h9ABC) $display("FAIL rfresh_word: got %h required 9abc", outWord); else nPass++;
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        nChecks     = 0;
        nPass       = 0;
        inRst       = 1'b1;
        inNibData   = 4'h0;
        inNibValid  = 1'b0;
        inFlush     = 1'b0;
        inWordReady = 1'b0;
        test_reset();
        test_basic();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_merge();
        test_back_to_back();
        test_reset_mid();
        nChecks++;
        if (expQ.size() != 0) $display("FAIL queue_empty: got %0d required 0", expQ.size());
        else nPass++;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
